// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: RV32I opcodes, the
// reservation-station one-hot select, immediate formats and the issue bundle.
package decode_issue_pkg;

    localparam int XLEN         = 32;
    localparam int THREAD_WIDTH = 2;
    localparam int INSTR_WIDTH  = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        RS_NONE = 3'b000,
        RS_ALU  = 3'b001,
        RS_LSU  = 3'b010,
        RS_BR   = 3'b100
    } rs_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        rs_sel_e                 rs;
        logic [THREAD_WIDTH-1:0] thread_id;
        logic [XLEN-1:0]         pc;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [2:0]              funct3;
        logic                    funct7b5;
        logic [6:0]              opcode;
        logic [XLEN-1:0]         imm;
        logic                    illegal;
    } issue_t;

    // Unknown opcodes go to the ALU so the illegal-instruction exception
    // is raised in program order.
    function automatic rs_sel_e opcode_rs(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_STORE:            return RS_LSU;
            OPC_BRANCH, OPC_JAL, OPC_JALR:  return RS_BR;
            default:                        return RS_ALU;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_imm_gen.sv
// Immediate generator: classifies the RV32I immediate format from the opcode
// and produces the sign-extended immediate. Purely combinational.
//   instr    : raw instruction
//   imm_type : immediate format (IMM_NONE for OP and unrecognised opcodes)
//   imm      : sign-extended immediate, zero when imm_type is IMM_NONE
module decode_issue_imm_gen
    import decode_issue_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    output imm_type_e              imm_type,
    output logic [XLEN-1:0]        imm
);

    always_comb begin
        imm_type = IMM_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type = IMM_I;
            OPC_STORE:                      imm_type = IMM_S;
            OPC_BRANCH:                     imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
            OPC_JAL:                        imm_type = IMM_J;
            default:                        imm_type = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: pops the fall-through fetch FIFO, decodes the RV32I
// fields and holds the result in a single-entry issue register until the
// selected reservation station accepts it.
//   clk, rst                  : clock, async active-high reset
//   stall_i                   : global freeze (no pop, no issue)
//   fifo_*_i / decode_ack_o   : FIFO head and pop strobe
//   flush_i, flush_thread_i   : discard head and issue entry of one thread
//   rs_ready_i                : per-station accept {BR, LSU, ALU}
//   issue_*_o                 : issue register contents, issue_cnt_o counts fires
//
// state | meaning
// EMPTY | issue register free, any unflushed head is loaded
// FULL  | issue register valid, waiting for its station to accept
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int XLEN         = decode_issue_pkg::XLEN,
    parameter int THREAD_WIDTH = decode_issue_pkg::THREAD_WIDTH,
    parameter int INSTR_WIDTH  = decode_issue_pkg::INSTR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    fifo_empty_i,
    input  logic [THREAD_WIDTH-1:0] fifo_thread_id_i,
    input  logic [XLEN-1:0]         fifo_pc_i,
    input  logic [INSTR_WIDTH-1:0]  fifo_instr_i,
    output logic                    decode_ack_o,
    input  logic                    flush_i,
    input  logic [THREAD_WIDTH-1:0] flush_thread_i,
    input  logic [2:0]              rs_ready_i,
    output logic                    issue_valid_o,
    output logic [2:0]              issue_rs_o,
    output logic [THREAD_WIDTH-1:0] issue_thread_id_o,
    output logic [XLEN-1:0]         issue_pc_o,
    output logic [4:0]              issue_rd_o,
    output logic [4:0]              issue_rs1_o,
    output logic [4:0]              issue_rs2_o,
    output logic [2:0]              issue_funct3_o,
    output logic                    issue_funct7b5_o,
    output logic [6:0]              issue_opcode_o,
    output logic [XLEN-1:0]         issue_imm_o,
    output logic                    issue_illegal_o,
    output logic [31:0]             issue_cnt_o
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e      state_q, state_d;
    issue_t      issue_q, issue_d, head_dec;
    logic [31:0] cnt_q, cnt_d;
    imm_type_e   head_imm_type;
    logic [XLEN-1:0] head_imm;
    logic        head_flushed, issue_flushed, fire, pop, load;

    decode_issue_imm_gen u_imm_gen (
        .instr    (fifo_instr_i),
        .imm_type (head_imm_type),
        .imm      (head_imm)
    );

    always_comb begin
        head_dec           = '0;
        head_dec.rs        = opcode_rs(fifo_instr_i[6:0]);
        head_dec.thread_id = fifo_thread_id_i;
        head_dec.pc        = fifo_pc_i;
        head_dec.rd        = fifo_instr_i[11:7];
        head_dec.rs1       = fifo_instr_i[19:15];
        head_dec.rs2       = fifo_instr_i[24:20];
        head_dec.funct3    = fifo_instr_i[14:12];
        head_dec.funct7b5  = fifo_instr_i[30];
        head_dec.opcode    = fifo_instr_i[6:0];
        head_dec.imm       = head_imm;
        // OP is the only legal opcode without an immediate format.
        head_dec.illegal   = (head_imm_type == IMM_NONE) && (fifo_instr_i[6:0] != OPC_OP);
    end

    always_comb begin
        state_d       = state_q;
        issue_d       = issue_q;
        head_flushed  = flush_i && (fifo_thread_id_i == flush_thread_i);
        // Flush of the held entry wins over acceptance and ignores stall.
        issue_flushed = (state_q == ST_FULL) && flush_i &&
                        (issue_q.thread_id == flush_thread_i);
        fire          = (state_q == ST_FULL) && |(issue_q.rs & rs_ready_i) &&
                        !stall_i && !issue_flushed;
        pop           = !rst && !fifo_empty_i && !stall_i &&
                        (head_flushed || (state_q == ST_EMPTY) || fire);
        load          = pop && !head_flushed;
        cnt_d         = cnt_q + {31'b0, fire};

        if (issue_flushed) begin
            state_d = ST_EMPTY;
            issue_d = '0;
        end else if (load) begin
            state_d = ST_FULL;
            issue_d = head_dec;
        end else if (fire) begin
            state_d = ST_EMPTY;
            issue_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            issue_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            cnt_q   <= cnt_d;
        end
    end

    assign decode_ack_o      = pop;
    assign issue_valid_o     = (state_q == ST_FULL);
    assign issue_rs_o        = issue_q.rs;
    assign issue_thread_id_o = issue_q.thread_id;
    assign issue_pc_o        = issue_q.pc;
    assign issue_rd_o        = issue_q.rd;
    assign issue_rs1_o       = issue_q.rs1;
    assign issue_rs2_o       = issue_q.rs2;
    assign issue_funct3_o    = issue_q.funct3;
    assign issue_funct7b5_o  = issue_q.funct7b5;
    assign issue_opcode_o    = issue_q.opcode;
    assign issue_imm_o       = issue_q.imm;
    assign issue_illegal_o   = issue_q.illegal;
    assign issue_cnt_o       = cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        fifo_empty_i;
    logic [1:0]  fifo_thread_id_i;
    logic [31:0] fifo_pc_i;
    logic [31:0] fifo_instr_i;
    logic        decode_ack_o;
    logic        flush_i;
    logic [1:0]  flush_thread_i;
    logic [2:0]  rs_ready_i;
    logic        issue_valid_o;
    logic [2:0]  issue_rs_o;
    logic [1:0]  issue_thread_id_o;
    logic [31:0] issue_pc_o;
    logic [4:0]  issue_rd_o;
    logic [4:0]  issue_rs1_o;
    logic [4:0]  issue_rs2_o;
    logic [2:0]  issue_funct3_o;
    logic        issue_funct7b5_o;
    logic [6:0]  issue_opcode_o;
    logic [31:0] issue_imm_o;
    logic        issue_illegal_o;
    logic [31:0] issue_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_thread_id_i  (fifo_thread_id_i),
        .fifo_pc_i         (fifo_pc_i),
        .fifo_instr_i      (fifo_instr_i),
        .decode_ack_o      (decode_ack_o),
        .flush_i           (flush_i),
        .flush_thread_i    (flush_thread_i),
        .rs_ready_i        (rs_ready_i),
        .issue_valid_o     (issue_valid_o),
        .issue_rs_o        (issue_rs_o),
        .issue_thread_id_o (issue_thread_id_o),
        .issue_pc_o        (issue_pc_o),
        .issue_rd_o        (issue_rd_o),
        .issue_rs1_o       (issue_rs1_o),
        .issue_rs2_o       (issue_rs2_o),
        .issue_funct3_o    (issue_funct3_o),
        .issue_funct7b5_o  (issue_funct7b5_o),
        .issue_opcode_o    (issue_opcode_o),
        .issue_imm_o       (issue_imm_o),
        .issue_illegal_o   (issue_illegal_o),
        .issue_cnt_o       (issue_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic [1:0] tid, input logic [31:0] pc, input logic [31:0] instr);
        fifo_empty_i     = 1'b0;
        fifo_thread_id_i = tid;
        fifo_pc_i        = pc;
        fifo_instr_i     = instr;
    endtask

    task automatic no_head();
        fifo_empty_i     = 1'b1;
        fifo_thread_id_i = 2'd0;
        fifo_pc_i        = 32'h0;
        fifo_instr_i     = 32'h0;
    endtask

    initial begin
        rst            = 1'b1;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        flush_thread_i = 2'd0;
        rs_ready_i     = 3'b111;
        head(2'd1, 32'h100, 32'h00500093);
        cycle();
        cycle();
        chk("rst_valid", {31'b0, issue_valid_o}, 32'd0);
        chk("rst_rs", {29'b0, issue_rs_o}, 32'd0);
        chk("rst_pc", issue_pc_o, 32'd0);
        chk("rst_cnt", issue_cnt_o, 32'd0);
        chk("rst_ack", {31'b0, decode_ack_o}, 32'd0);

        // addi x1,x0,5 from thread 1
        rst = 1'b0;
        #1;
        chk("addi_ack", {31'b0, decode_ack_o}, 32'd1);
        cycle();
        no_head();
        #1;
        chk("addi_valid", {31'b0, issue_valid_o}, 32'd1);
        chk("addi_rs", {29'b0, issue_rs_o}, 32'b001);
        chk("addi_rd", {27'b0, issue_rd_o}, 32'd1);
        chk("addi_rs1", {27'b0, issue_rs1_o}, 32'd0);
        chk("addi_imm", issue_imm_o, 32'h5);
        chk("addi_tid", {30'b0, issue_thread_id_o}, 32'd1);
        chk("addi_pc", issue_pc_o, 32'h100);
        cycle();
        chk("addi_cnt", issue_cnt_o, 32'd1);
        chk("addi_drained", {31'b0, issue_valid_o}, 32'd0);

        // sw x2,-4(x1) with the LSU busy for three cycles
        rs_ready_i = 3'b101;
        head(2'd0, 32'h104, 32'hFE20AE23);
        #1;
        cycle();
        head(2'd0, 32'h108, 32'h00A00193);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sw_rs", {29'b0, issue_rs_o}, 32'b010);
            chk("sw_imm", issue_imm_o, 32'hFFFFFFFC);
            chk("sw_rs2", {27'b0, issue_rs2_o}, 32'd2);
            chk("sw_ack_held", {31'b0, decode_ack_o}, 32'd0);
            if (i < 2) cycle();
        end
        rs_ready_i = 3'b111;
        #1;
        chk("sw_fire_ack", {31'b0, decode_ack_o}, 32'd1);
        cycle();
        no_head();
        #1;
        chk("next_pc", issue_pc_o, 32'h108);
        chk("next_rd", {27'b0, issue_rd_o}, 32'd3);
        chk("next_imm", issue_imm_o, 32'd10);
        chk("sw_cnt", issue_cnt_o, 32'd2);
        cycle();
        chk("next_cnt", issue_cnt_o, 32'd3);

        // lui then jal back-to-back
        head(2'd0, 32'h200, 32'h123452B7);
        cycle();
        head(2'd0, 32'h204, 32'hFFDFF06F);
        #1;
        chk("lui_rs", {29'b0, issue_rs_o}, 32'b001);
        chk("lui_imm", issue_imm_o, 32'h12345000);
        chk("lui_rd", {27'b0, issue_rd_o}, 32'd5);
        chk("b2b_ack", {31'b0, decode_ack_o}, 32'd1);
        cycle();
        no_head();
        #1;
        chk("jal_rs", {29'b0, issue_rs_o}, 32'b100);
        chk("jal_imm", issue_imm_o, 32'hFFFFFFFC);
        chk("jal_valid", {31'b0, issue_valid_o}, 32'd1);
        chk("lui_cnt", issue_cnt_o, 32'd4);
        cycle();
        chk("jal_cnt", issue_cnt_o, 32'd5);

        // flush thread 2: held entry and head dropped, fire suppressed
        rs_ready_i = 3'b000;
        head(2'd2, 32'h300, 32'h00500093);
        cycle();
        chk("fl_loaded_tid", {30'b0, issue_thread_id_o}, 32'd2);
        head(2'd2, 32'h304, 32'h00500093);
        rs_ready_i     = 3'b001;
        flush_i        = 1'b1;
        flush_thread_i = 2'd2;
        #1;
        chk("fl_head_ack", {31'b0, decode_ack_o}, 32'd1);
        cycle();
        flush_i = 1'b0;
        no_head();
        #1;
        chk("fl_valid", {31'b0, issue_valid_o}, 32'd0);
        chk("fl_cnt", issue_cnt_o, 32'd5);
        cycle();
        chk("fl_discarded", {31'b0, issue_valid_o}, 32'd0);

        // flush of another thread leaves thread 2 alone
        rs_ready_i = 3'b000;
        head(2'd2, 32'h308, 32'h00500093);
        cycle();
        head(2'd2, 32'h30C, 32'h00500093);
        flush_i        = 1'b1;
        flush_thread_i = 2'd3;
        #1;
        chk("fl3_ack", {31'b0, decode_ack_o}, 32'd0);
        cycle();
        flush_i = 1'b0;
        no_head();
        #1;
        chk("fl3_valid", {31'b0, issue_valid_o}, 32'd1);
        chk("fl3_pc", issue_pc_o, 32'h308);
        rs_ready_i = 3'b111;
        cycle();
        chk("fl3_cnt", issue_cnt_o, 32'd6);

        // illegal opcode, then a two-cycle stall
        head(2'd0, 32'h400, 32'hFFFFFFFF);
        cycle();
        head(2'd0, 32'h404, 32'h00500093);
        stall_i = 1'b1;
        #1;
        chk("ill_rs", {29'b0, issue_rs_o}, 32'b001);
        chk("ill_flag", {31'b0, issue_illegal_o}, 32'd1);
        chk("ill_imm", issue_imm_o, 32'h0);
        chk("stall_ack", {31'b0, decode_ack_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall_pc", issue_pc_o, 32'h400);
            chk("stall_ill", {31'b0, issue_illegal_o}, 32'd1);
            chk("stall_cnt", issue_cnt_o, 32'd6);
        end
        stall_i = 1'b0;
        #1;
        chk("unstall_ack", {31'b0, decode_ack_o}, 32'd1);
        cycle();
        no_head();
        rs_ready_i = 3'b000;
        #1;
        chk("unstall_pc", issue_pc_o, 32'h404);
        chk("unstall_ill", {31'b0, issue_illegal_o}, 32'd0);
        chk("unstall_cnt", issue_cnt_o, 32'd7);

        // async reset between edges while FULL
        head(2'd1, 32'h500, 32'h00500093);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, issue_valid_o}, 32'd0);
        chk("arst_cnt", issue_cnt_o, 32'd0);
        chk("arst_ack", {31'b0, decode_ack_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("arst_rel_ack", {31'b0, decode_ack_o}, 32'd1);
        cycle();
        chk("arst_resume_valid", {31'b0, issue_valid_o}, 32'd1);
        chk("arst_resume_pc", issue_pc_o, 32'h500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
